conv_weight_fetch_ctrl: RTL
===========================

// Module: conv_weight_fetch_ctrl
// PURPOSE
//  Sequences the single-port conv weight ROM (1-cycle registered read, no clk_en) for one conv layer.
//  On start, it reads num_words consecutive 144-bit weight words from base_addr.
//  It streams them to the conv engine over valid/ready.
//  A 3-entry buffer absorbs engine backpressure, because the ROM read cannot be stalled.
// PARAMETERS
//  ADDR_WIDTH  8    ROM address width
//  DATA_WIDTH  144  ROM word width (9 x 16-bit 3x3 kernel taps)
//  LEN_WIDTH   9    width of num_words (0..256)
//  BUF_DEPTH   3    output buffer entries (>=3 for 1 word/cycle)
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           synchronous active-low reset
//  start      in   1           1-cycle pulse; sampled only in IDLE
//  abort      in   1           flush and return to IDLE, no done
//  base_addr  in   ADDR_WIDTH  first ROM word of the layer
//  num_words  in   LEN_WIDTH   words to fetch
//  busy       out  1           high from accepted start until done/abort
//  done       out  1           1-cycle pulse after last beat handshake
//  rom_addr   out  ADDR_WIDTH  to ROM addr
//  rom_data   in   DATA_WIDTH  from ROM rd_data, valid 1 cycle after rom_addr
//  w_valid    out  1           weight word available
//  w_data     out  DATA_WIDTH  weight word
//  w_last     out  1           marks final word of the layer
//  w_ready    in   1           engine accepts word
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE.
//   busy=0, done=0, w_valid=0, w_last=0, rom_addr=0, buffer empty, in-flight flag cleared.
//  FSM states: IDLE, FETCH, DRAIN, DONE.
//   IDLE->FETCH on start with num_words!=0.
//     Latch base_addr into addr_cnt and num_words into issue_cnt/beat_cnt.
//   IDLE->DONE on start with num_words==0. No ROM read and no beat occur.
//   FETCH->DRAIN when the last address is issued.
//   DRAIN->DONE on the handshake (w_valid&w_ready) of the beat with w_last=1.
//   DONE->IDLE unconditionally. done=1 only in DONE.
//  start in any state other than IDLE is ignored; operands are not re-latched.
//  Issue rule (FETCH): issue when occupancy + inflight - pop < BUF_DEPTH.
//   pop = w_valid & w_ready.
//   On issue: rom_addr <= addr_cnt (registered); addr_cnt++; issue_cnt--; inflight <= 1.
//   Without issue: inflight <= 0 and rom_addr holds its value. The ROM output is ignored.
//  Capture: when inflight=1, rom_data is pushed into the buffer that cycle.
//   The credit rule guarantees the push never overflows.
//  Latency: start at cycle 0 -> rom_addr=base at cycle 1 -> push at cycle 2.
//   w_valid=1 with word[base] at cycle 3.
//  Throughput: with w_ready held at 1, one word per cycle after the first.
//  w_data/w_valid come straight from buffer storage with no combinational path from rom_data.
//   w_data is stable while w_valid=1 and w_ready=0.
//  w_last=1 exactly when the head entry is the word-count'th word.
//   Tracked with beat_cnt, decremented on pop.
//  Address wrap: addr_cnt wraps modulo 2^ADDR_WIDTH (0xFF -> 0x00). No error is raised.
//  busy=1 in FETCH, DRAIN and DONE.
//  abort has priority over everything except reset. In any state, on the next cycle:
//   state=IDLE, buffer flushed, inflight=0, w_valid=0, no done pulse.
//   The ROM word returning that cycle is discarded.
//  start and abort in the same IDLE cycle: abort wins and the start is dropped.
//  Push and pop in the same cycle: occupancy is unchanged and order is preserved.
// STRUCTURE
//  conv_pkg (shared):
//   - ROM geometry constants WROM_ADDR_W=8, WROM_DATA_W=144.
//   - typedef wfetch_state_t {IDLE, FETCH, DRAIN, DONE}.
//  Sub-module wfetch_buf: DEPTH x DATA_WIDTH synchronous FIFO.
//   - Signals: push/pop/flush, occupancy count, registered head.
//   - Behaviour: no overflow on push when full; the controller guarantees the issue rule.
//  Top level: FSM, counters and credit logic. Target ~200 lines of RTL.
// TESTING
//  Use a ROM model with 1-cycle latency where word[a] = {16{a[7:0]},16'hA5A5}-style tags.
//  1. start base=0x10 n=4, w_ready=1.
//     -> w_valid at cycle 3..6 with words 0x10..0x13; w_last at cycle 6; done at cycle 7; busy low at cycle 8.
//  2. n=8 with w_ready toggling 1,0,0,1,...
//     -> all 8 words in order, no duplicates or drops; w_data stable while stalled; never >3 buffered.
//  3. base=0xFE n=4 -> words 0xFE,0xFF,0x00,0x01; w_last on 0x01.
//  4. start n=0 -> done the next cycle, w_valid never asserted, rom_addr unchanged.
//  5. abort after 2 of 6 beats, with w_ready=0 and the buffer full.
//     -> next cycle IDLE, w_valid=0, busy=0, no done.
//     A new start base=0x40 n=2 then yields only words 0x40,0x41.
//  6. start pulsed again mid-FETCH, and rst_n=0 mid-DRAIN.
//     -> the second start has no effect.
//     -> reset forces all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared conv-layer definitions: weight ROM geometry and the weight fetch FSM state type.
package conv_pkg;

  localparam int WROM_ADDR_W = 8;
  localparam int WROM_DATA_W = 144;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wfetch_state_t;

endpackage

// File: rtl/wfetch_buf.sv
// Small shift-register FIFO; the head entry is always in mem[0], so the output is pure storage.
module wfetch_buf #(
  parameter int DEPTH      = 3,
  parameter int DATA_WIDTH = 144,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  pop_eff;
  logic                  push_eff;
  logic [CNT_W-1:0]      wr_idx;

  assign pop_eff  = pop && (count != '0);
  assign push_eff = push && ((count != CNT_W'(DEPTH)) || pop_eff);
  // A simultaneous pop shifts everything down, so the new word lands one slot lower.
  assign wr_idx   = count - CNT_W'(pop_eff);
  assign head     = mem[0];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_eff && (wr_idx == CNT_W'(i))) begin
        mem[i] <= push_data;
      end else if (pop_eff && (i < DEPTH - 1)) begin
        mem[i] <= mem[(i < DEPTH - 1) ? i + 1 : i];
      end
    end
  end

endmodule

// File: rtl/conv_weight_fetch_ctrl.sv
// Streams one conv layer's weight words from the 1-cycle-latency ROM to the engine,
// issuing reads only when the output buffer is guaranteed room for the returning word.
module conv_weight_fetch_ctrl
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = WROM_ADDR_W,
  parameter int DATA_WIDTH = WROM_DATA_W,
  parameter int LEN_WIDTH  = 9,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  w_valid,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last,
  input  logic                  w_ready
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = OCC_W + 2;

  wfetch_state_t         state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  req_p0;
  logic                  inflight_p1;
  logic [OCC_W-1:0]      occ;
  logic                  pop;
  logic [SUM_W-1:0]      credit_used;
  logic                  issue_ok;

  assign pop         = w_valid && w_ready;
  assign w_valid     = (occ != '0);
  assign w_last      = w_valid && (beat_cnt == LEN_WIDTH'(1));
  // Both the address-stage and data-stage reads will land in the buffer, so both hold credit.
  assign credit_used = SUM_W'(occ) + SUM_W'(req_p0) + SUM_W'(inflight_p1);
  assign issue_ok    = (state == FETCH) && (credit_used < SUM_W'(BUF_DEPTH) + SUM_W'(pop));

  wfetch_buf #(
    .DEPTH      (BUF_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (OCC_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_p1),
    .push_data (rom_data),
    .pop       (pop),
    .flush     (abort),
    .count     (occ),
    .head      (w_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_addr    <= '0;
      addr_cnt    <= '0;
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      req_p0      <= 1'b0;
      inflight_p1 <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_p0      <= 1'b0;
      inflight_p1 <= 1'b0;
    end else begin
      // ---- address stage -> data stage ----
      inflight_p1 <= req_p0;
      req_p0      <= 1'b0;
      done        <= 1'b0;
      if (pop) begin
        beat_cnt <= beat_cnt - LEN_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              // First read goes out on the accepting edge to hit the 3-cycle latency.
              rom_addr  <= base_addr;
              req_p0    <= 1'b1;
              addr_cnt  <= base_addr + ADDR_WIDTH'(1);
              issue_cnt <= num_words - LEN_WIDTH'(1);
              beat_cnt  <= num_words;
              state     <= (num_words == LEN_WIDTH'(1)) ? DRAIN : FETCH;
            end
          end
        end
        FETCH: begin
          if (issue_ok) begin
            rom_addr  <= addr_cnt;
            req_p0    <= 1'b1;
            addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
            issue_cnt <= issue_cnt - LEN_WIDTH'(1);
            if (issue_cnt == LEN_WIDTH'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && w_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
